// File: rtl/bit_serializer.sv
// bit_serializer: shifts a byte out LSB first as timed write strobes.
// Optional status watchdog enabled by defining BIT_SERIALIZER_TIMEOUT_EN.
module bit_serializer #(
  parameter int HOLD_CYCLES = 10,
  parameter int GAP_CYCLES  = 10
) (
  input  logic       clock_1MHz,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       status_in,
  output logic       data_out,
  output logic       write_out,
  output logic       busy,
  output logic       err_out
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    HIGH,
    LOW,
    WAIT_DONE
  } state_t;

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES);
  localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES);

  state_t     state;
  state_t     state_d;
  logic       live;
  logic [7:0] shreg;
  logic [7:0] cnt;
  logic [3:0] bits;
  logic       accept;
  logic       ld_hold;
  logic       ld_gap;
  logic       dec;
  logic       shift;
  logic       wd_hit;

  // live holds byte_ready low until the first edge after reset release.
  assign byte_ready = live && (state == IDLE);
  assign write_out  = (state == HIGH);
  assign busy       = (state != IDLE);

`ifdef BIT_SERIALIZER_TIMEOUT_EN
  logic [7:0] wd;
  logic       waiting;
  logic       err_q;

  assign waiting = (state == WAIT_RDY) || (state == WAIT_DONE);
  assign wd_hit  = waiting && (wd == 8'd254);
  assign err_out = err_q;

  // Count cycles spent waiting on status_in; pulse err on expiry.
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      if (waiting && (state_d == state)) begin
        wd <= wd + 8'd1;
      end else begin
        wd <= '0;
      end
      if (state == WAIT_RDY) begin
        err_q <= wd_hit && !status_in;
      end else begin
        err_q <= wd_hit && status_in;
      end
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign err_out = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    ld_hold = 1'b0;
    ld_gap  = 1'b0;
    dec     = 1'b0;
    shift   = 1'b0;
    unique case (state)
      IDLE: begin
        if (live && byte_valid) begin
          accept  = 1'b1;
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (status_in) begin
          ld_hold = 1'b1;
          state_d = HIGH;
        end else if (wd_hit) begin
          state_d = IDLE;
        end
      end
      HIGH: begin
        if (cnt == 8'd1) begin
          ld_gap  = 1'b1;
          state_d = LOW;
        end else begin
          dec = 1'b1;
        end
      end
      LOW: begin
        if (cnt == 8'd1) begin
          shift = 1'b1;
          if (bits == 4'd7) begin
            state_d = WAIT_DONE;
          end else begin
            ld_hold = 1'b1;
            state_d = HIGH;
          end
        end else begin
          dec = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!status_in || wd_hit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shift register, bit counter, phase counter and data_out.
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      live     <= 1'b0;
      shreg    <= '0;
      cnt      <= '0;
      bits     <= '0;
      data_out <= 1'b0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        shreg <= byte_in;
        bits  <= '0;
      end
      if (shift) begin
        shreg <= {1'b0, shreg[7:1]};
        bits  <= bits + 4'd1;
      end
      if (ld_hold) begin
        cnt      <= HOLD_LD;
        data_out <= shift ? shreg[1] : shreg[0];
      end else if (ld_gap) begin
        cnt <= GAP_LD;
      end else if (dec) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: randomized scoreboard bench for bit_serializer.
// Bit values and pulse timing are checked by a negedge monitor.
`timescale 1ns/1ps
module tb_bit_serializer;

  localparam int HOLD = 10;
  localparam int GAP  = 10;
  localparam int BYTE_LEN = 8 * (HOLD + GAP);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       status_in = 1'b0;
  logic       byte_ready;
  logic       data_out;
  logic       write_out;
  logic       busy;
  logic       err_out;

  bit_serializer #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP)
  ) dut (
    .clock_1MHz(clk),
    .rst       (rst),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .status_in (status_in),
    .data_out  (data_out),
    .write_out (write_out),
    .busy      (busy),
    .err_out   (err_out)
  );

  always #500 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  bit exp_q[$];
  int npulse = 0;
  int n_err  = 0;

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_chk++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected bit per write_out rise, checks timing.
  bit prev_w = 1'b0;
  int pidx = 0;
  int last_rise = 0;
  bit cur = 1'b0;
  bit stable = 1'b0;
  bit eb;

  always @(negedge clk) begin
    if (!rst) begin
      prev_w = 1'b0;
      pidx   = 0;
    end else begin
      if (err_out === 1'b1) n_err++;
      if (write_out === 1'b1 && !prev_w) begin
        npulse++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          eb = exp_q.pop_front();
          check("bit_value", data_out, eb);
        end
        if (pidx % 8 != 0) check("bit_period", cyc - last_rise, HOLD + GAP);
        pidx++;
        last_rise = cyc;
        cur = data_out;
        stable = 1'b1;
      end
      if (write_out !== 1'b1 && prev_w) check("hold_len", cyc - last_rise, HOLD);
      if (pidx > 0 && (cyc - last_rise) < HOLD + GAP) begin
        if (data_out !== cur) stable = 1'b0;
        if (cyc - last_rise == HOLD + GAP - 1) check("data_stable", stable, 1);
      end
      prev_w = (write_out === 1'b1);
    end
  end

  task automatic wait_ready(input int lim);
    int k = 0;
    while (byte_ready !== 1'b1 && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (byte_ready !== 1'b1) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_rise(input int lim, output int t);
    int k = 0;
    while (write_out === 1'b1 && k < lim) begin
      @(negedge clk);
      k++;
    end
    while (write_out !== 1'b1 && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (write_out !== 1'b1) check("rise_timeout", 0, 1);
    t = cyc;
  endtask

  // Reference model: a byte becomes 8 strobes, least significant first.
  task automatic expect_byte(input logic [7:0] b);
    int v = int'(b);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(bit'(v % 2));
      v = v / 2;
    end
  endtask

  task automatic send(input logic [7:0] b, output int acc);
    wait_ready(2000);
    byte_in = b;
    byte_valid = 1'b1;
    expect_byte(b);
    @(negedge clk);
    byte_valid = 1'b0;
    acc = cyc;
  endtask

  initial begin
    #60000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc;
    int first;
    int t;
    int k;
    int p0;
    int e0;
    int dly;
    int hold;
    int exp_idle;
    logic [7:0] b;

    // Reset state.
    #100 rst = 1'b0;
    #1;
    check("rst_byte_ready", byte_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_write_out", write_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_err_out", err_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("ready_before_edge", byte_ready, 0);
    @(posedge clk);
    #1 check("ready_after_edge", byte_ready, 1);
    @(negedge clk);

    // 0xAA with status already high; status drops mid-byte.
    status_in = 1'b1;
    send(8'hAA, acc);
    check("a_busy", busy, 1);
    check("a_not_ready", byte_ready, 0);
    wait_rise(100, first);
    check("a_wait_rdy_len", first, acc + 1);
    repeat (50) @(negedge clk);
    status_in = 1'b0;
    wait_ready(400);
    check("a_byte_len", cyc, first + BYTE_LEN + 1);
    check("a_drained", exp_q.size(), 0);

    // 0x01 with status low for 50 cycles.
    send(8'h01, acc);
    p0 = npulse;
    repeat (50) @(negedge clk);
    check("b_no_write", npulse - p0, 0);
    check("b_waiting", busy, 1);
    status_in = 1'b1;
    t = cyc;
    wait_rise(100, first);
    check("b_start", first, t + 1);
    repeat (60) @(negedge clk);
    status_in = 1'b0;
    wait_ready(400);
    check("b_drained", exp_q.size(), 0);

    // byte_valid held: 0x3C then 0xC3.
    status_in = 1'b1;
    wait_ready(100);
    byte_in = 8'h3C;
    byte_valid = 1'b1;
    expect_byte(8'h3C);
    @(negedge clk);
    acc = cyc;
    byte_in = 8'hC3;
    wait_rise(100, first);
    check("c_first", first, acc + 1);
    while (cyc < first + BYTE_LEN + 200) @(negedge clk);
    check("c_no_latch", byte_ready, 0);
    check("c_wait_done", busy, 1);
    check("c_drained", exp_q.size(), 0);
    expect_byte(8'hC3);
    status_in = 1'b0;
    t = cyc;
    wait_ready(10);
    check("c_idle_time", cyc, t + 1);
    @(negedge clk);
    acc = cyc;
    byte_valid = 1'b0;
    check("c_second_latched", busy, 1);
    status_in = 1'b1;
    wait_rise(100, first);
    check("c2_first", first, acc + 1);
    repeat (40) @(negedge clk);
    status_in = 1'b0;
    wait_ready(400);
    check("c2_drained", exp_q.size(), 0);

    // Randomized bytes, status delays and release points.
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      dly = int'($urandom_range(0, 20));
      status_in = (dly == 0);
      send(b, acc);
      if (dly != 0) begin
        repeat (dly) @(negedge clk);
        status_in = 1'b1;
        t = cyc + 1;
      end else begin
        t = acc + 1;
      end
      wait_rise(100, first);
      check("r_first", first, t);
      hold = int'($urandom_range(1, 200));
      repeat (hold) @(negedge clk);
      status_in = 1'b0;
      k = cyc;
      exp_idle = first + BYTE_LEN + 1;
      if (k + 1 > exp_idle) exp_idle = k + 1;
      wait_ready(500);
      check("r_idle_time", cyc, exp_idle);
      check("r_drained", exp_q.size(), 0);
    end

    // Reset during the 4th HIGH phase.
    status_in = 1'b1;
    send(8'hFF, acc);
    for (int i = 0; i < 4; i++) wait_rise(200, t);
    @(negedge clk);
    #200 rst = 1'b0;
    #1;
    check("mid_rst_ready", byte_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_write", write_out, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_err", err_out, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 check("rel_ready_low", byte_ready, 0);
    @(posedge clk);
    #1 check("rel_ready_high", byte_ready, 1);
    p0 = npulse;
    repeat (300) @(negedge clk);
    check("no_residual", npulse - p0, 0);
    check("rel_idle", busy, 0);

    // status stays high after the byte.
    status_in = 1'b1;
    send(8'h5A, acc);
    wait_rise(100, first);
    e0 = n_err;
`ifdef BIT_SERIALIZER_TIMEOUT_EN
    while (err_out !== 1'b1 && cyc < first + BYTE_LEN + 400) @(negedge clk);
    check("err_time", cyc, first + BYTE_LEN + 255);
    check("err_ready", byte_ready, 1);
    @(negedge clk);
    check("err_one_cycle", err_out, 0);
    check("err_count", n_err - e0, 1);
`else
    while (cyc < first + BYTE_LEN + 300) @(negedge clk);
    check("stay_wait_done", busy, 1);
    check("stay_not_ready", byte_ready, 0);
    check("no_err", n_err - e0, 0);
`endif
    status_in = 1'b0;
    wait_ready(400);
    check("f_drained", exp_q.size(), 0);
`ifndef BIT_SERIALIZER_TIMEOUT_EN
    check("err_never", n_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter HOLD_CYCLES, default 10: clock cycles write_out stays high per bit, legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 10: clock cycles write_out stays low after each bit, legal range 1..255.
REQ-003 clock_1MHz  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 byte_in  input  8  parallel byte to transmit.
REQ-006 byte_valid  input  1  byte_in is valid this cycle.
REQ-007 byte_ready  output  1  block can accept a byte.
REQ-008 status_in  input  1  downstream deserializer ready; connects to the deserializer's status_out.
REQ-009 data_out  output  1  serial bit; connects to the downstream data_in.
REQ-010 write_out  output  1  bit strobe; connects to the downstream write_in.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 err_out  output  1  one-cycle timeout pulse (REQ-031).

Function
REQ-013 FSM states SHALL be IDLE, WAIT_RDY, HIGH, LOW and WAIT_DONE.
REQ-014 IDLE: byte_ready=1; on byte_valid=1, byte_in SHALL be latched into an 8-bit shift register, the bit counter cleared, and the FSM SHALL move to WAIT_RDY.
REQ-015 byte_ready SHALL be 0 in every non-IDLE state; byte_valid SHALL be ignored there and no byte SHALL be lost or double-latched.
REQ-016 WAIT_RDY: the FSM SHALL stay until status_in is sampled 1, then move to HIGH on the next edge.
REQ-017 HIGH: write_out=1 for exactly HOLD_CYCLES cycles, then the FSM SHALL move to LOW.
REQ-018 LOW: write_out=0 for exactly GAP_CYCLES cycles; afterwards the register SHALL shift right and the counter increment.
REQ-019 After the LOW phase, counter<8 SHALL return to HIGH, and counter=8 SHALL go to WAIT_DONE.
REQ-020 Bits SHALL be sent LSB first.
REQ-021 data_out SHALL equal the current bit for the whole HIGH and LOW window; it changes only on the HIGH entry edge.
REQ-022 Byte duration from the first write_out rise to WAIT_DONE entry SHALL be exactly 8*(HOLD_CYCLES+GAP_CYCLES) cycles.
REQ-023 A status_in deassertion during HIGH/LOW SHALL NOT abort the byte; all 8 bits are always sent.
REQ-024 WAIT_DONE: the FSM SHALL stay until status_in is sampled 0, then go to IDLE.
REQ-025 A byte_valid in the cycle WAIT_DONE exits SHALL be ignored; acceptance starts in IDLE.
REQ-026 The hold and gap counters SHALL be 8 bits wide and SHALL count down from the parameter value to 1 with no wrap.
REQ-027 If status_in is already 1 when a byte is latched, WAIT_RDY SHALL last exactly 1 cycle.

Reset
REQ-028 On rst=0, the block SHALL immediately force the FSM to IDLE and set byte_ready=0, busy=0, write_out=0, data_out=0, err_out=0, and all counters and the shift register to 0, regardless of clock.
REQ-029 byte_ready SHALL rise on the first clock edge after rst returns to 1.
REQ-030 A reset mid-byte SHALL discard the byte; no further write_out pulses occur.

Configuration
REQ-031 With BIT_SERIALIZER_TIMEOUT_EN defined, an 8-bit watchdog SHALL run in WAIT_RDY and WAIT_DONE; if status_in does not reach the awaited level within 255 cycles, err_out SHALL pulse 1 cycle and the FSM SHALL go to IDLE.
REQ-032 Without BIT_SERIALIZER_TIMEOUT_EN, no watchdog SHALL exist, err_out SHALL be tied to 0, and the FSM SHALL wait indefinitely.

Verification
REQ-033 Send byte 0xAA with status_in=1 and defaults -> data_out sequence 0,1,0,1,0,1,0,1, each write_out pulse 10 high and 10 low, 160 cycles total.
REQ-034 Send byte 0x01 with status_in=0 for 50 cycles, then 1 -> no write_out while status_in=0; the first pulse has data_out=1 and the next 7 pulses have data_out=0.
REQ-035 Assert byte_valid continuously with 0x3C then 0xC3 -> 0x3C is fully sent; 0xC3 is latched only after status_in falls and the FSM re-enters IDLE.
REQ-036 Assert rst=0 during the 4th HIGH phase -> all outputs are 0 the same cycle; after release, byte_ready=1 and no residual pulses occur.
REQ-037 With BIT_SERIALIZER_TIMEOUT_EN, hold status_in=1 after the byte -> err_out pulses once 255 cycles after WAIT_DONE entry, then byte_ready=1; without the macro, the FSM stays in WAIT_DONE.
